// File: rtl/bcd_seg_scan.sv
// Four-digit multiplexed 7-segment driver for BCD adder results.
// Shadow/display double buffering keeps the shown value stable for a whole frame.
module bcd_seg_scan #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic        ovf_in,
    input  logic        blank_en,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic        err,
    output logic        frame_done
);

    localparam logic [15:0] CNT_MAX = 16'(SCAN_DIV - 1);

    logic [15:0] cnt;
    logic [1:0]  idx;
    logic [15:0] shadow;
    logic        shadow_ovf;
    logic        pending;
    logic [15:0] disp;
    logic        disp_ovf;

    logic [6:0]  seg_p1;
    logic [3:0]  an_p1;
    logic        dp_p1;
    logic        err_p1;
    logic        frame_done_p1;

    logic        tick;
    logic        boundary;
    logic [3:0]  cur_digit;
    logic        blanked;
    logic        z3, z2, z1;
    logic [6:0]  seg_nxt;
    logic [3:0]  an_nxt;
    logic        dp_nxt;
    logic        err_nxt;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h40;
        endcase
    endfunction

    function automatic logic is_bad(input logic [3:0] v);
        is_bad = (v > 4'd9);
    endfunction

    assign tick     = (cnt == CNT_MAX);
    assign boundary = tick && (idx == 2'd3);

    // p0: select current digit, resolve leading-zero blanking and decode
    always_comb begin
        cur_digit = disp[3:0];
        blanked   = 1'b0;
        z3 = (disp[15:12] == 4'd0);
        z2 = z3 && (disp[11:8] == 4'd0);
        z1 = z2 && (disp[7:4] == 4'd0);
        case (idx)
            2'd0: cur_digit = disp[3:0];
            2'd1: begin cur_digit = disp[7:4];   blanked = blank_en && z1; end
            2'd2: begin cur_digit = disp[11:8];  blanked = blank_en && z2; end
            default: begin cur_digit = disp[15:12]; blanked = blank_en && z3; end
        endcase
        seg_nxt = blanked ? 7'h00 : seg_decode(cur_digit);
        an_nxt  = blanked ? 4'hF : ~(4'b0001 << idx);
        dp_nxt  = (idx == 2'd0) && disp_ovf;
        err_nxt = is_bad(disp[3:0]) || is_bad(disp[7:4]) ||
                  is_bad(disp[11:8]) || is_bad(disp[15:12]);
    end

    // p0 -> p1: scan state, buffering and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            idx           <= '0;
            shadow        <= '0;
            shadow_ovf    <= 1'b0;
            pending       <= 1'b0;
            disp          <= '0;
            disp_ovf      <= 1'b0;
            seg_p1        <= '0;
            an_p1         <= 4'hF;
            dp_p1         <= 1'b0;
            err_p1        <= 1'b0;
            frame_done_p1 <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 16'd1;
            if (tick) idx <= idx + 2'd1;
            // Commit reads the pre-load shadow, so a coinciding load waits one frame.
            if (boundary && pending) begin
                disp     <= shadow;
                disp_ovf <= shadow_ovf;
            end
            if (load) begin
                shadow     <= digits_in;
                shadow_ovf <= ovf_in;
                pending    <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
            seg_p1        <= seg_nxt;
            an_p1         <= an_nxt;
            dp_p1         <= dp_nxt;
            err_p1        <= err_nxt;
            frame_done_p1 <= boundary;
        end
    end

    assign seg        = seg_p1;
    assign an         = an_p1;
    assign dp         = dp_p1;
    assign err        = err_p1;
    assign frame_done = frame_done_p1;

endmodule

// File: doc/bcd_seg_scan.md
BCD_SEG_SCAN -- requirements
Module: bcd_seg_scan

Interface
REQ-001 Parameter: SCAN_DIV, default 50000, number of clock cycles each digit stays enabled; legal range 2..65535.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 Port: load  input  1  capture request for digits_in and ovf_in; a single-cycle pulse or held high.
REQ-005 Port: digits_in  input  16  four BCD digits from the adder stage; [3:0] is digit 0 (LSD), [15:12] is digit 3 (MSD).
REQ-006 Port: ovf_in  input  1  decimal carry-out of the adder chain, captured with digits_in.
REQ-007 Port: blank_en  input  1  enables leading-zero blanking; sampled live every cycle.
REQ-008 Port: seg  output  7  active-high segments {g,f,e,d,c,b,a}.
REQ-009 Port: an  output  4  active-low digit enables; an[i] drives digit i.
REQ-010 Port: dp  output  1  active-high decimal point.
REQ-011 Port: err  output  1  high while the display register holds any digit greater than 9.
REQ-012 Port: frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-013 Prescaler cnt counts 0..SCAN_DIV-1 and wraps to 0; a scan tick occurs in the cycle where cnt==SCAN_DIV-1.
REQ-014 On a scan tick, digit index idx advances 0->1->2->3->0; a tick with idx==3 is a frame boundary.
REQ-015 A load=1 cycle writes digits_in/ovf_in into the shadow register and sets pending; a later load before commit overwrites the shadow (last wins).
REQ-016 At a frame boundary with pending=1, the display register takes the shadow value and pending clears; the display never changes mid-frame.
REQ-017 If load coincides with a frame boundary, the commit uses the shadow contents from before that cycle; the new value stays in the shadow with pending=1 for the next boundary.
REQ-018 frame_done is 1 for exactly the cycle after each frame boundary, whether or not a commit occurred.
REQ-019 seg, an, dp and err are registered: they reflect idx and the display register with one cycle of latency.
REQ-020 Decode: 0=7'h3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F; any value 10..15 shows a dash (7'h40).
REQ-021 Exactly one an bit is low per cycle unless the selected digit is blanked; a blanked digit drives an=4'b1111 and seg=0.
REQ-022 When blank_en=1, digit i (i=3,2,1) is blanked if it and every more-significant digit equal 0; digit 0 is never blanked; invalid digits count as nonzero.
REQ-023 dp=1 only while digit 0 is selected and the displayed ovf bit is 1.
REQ-024 err is high while any displayed digit exceeds 9, independent of idx.

Reset
REQ-025 While rst=1 at a clock edge: cnt=0, idx=0, shadow=0, display=0, pending=0, seg=0, an=4'b1111, dp=0, err=0, frame_done=0.
REQ-026 rst has priority over load and the scan tick; a load in the same cycle as rst is discarded.
REQ-027 Reset mid-frame aborts the scan; the first cycle after rst falls displays digit 0 of the zeroed display (seg=7'h3F, an=4'b1110).

Verification (SCAN_DIV=4)
REQ-028 Reset, then idle for 16 cycles -> an cycles 1110,1101,1011,0111, each for 4 cycles; seg=7'h3F throughout; frame_done pulses once per 16 cycles.
REQ-029 load digits_in=16'h1234, ovf_in=1, mid-frame -> no display change until the frame boundary; next frame shows 4,3,2,1 (7'h66,4F,5B,06) with dp=1 only on digit 0.
REQ-030 blank_en=1, display 16'h0070 -> digits 3 and 2 blanked (an=1111, seg=0), digit 1=7'h07, digit 0=7'h3F; blank_en=0 restores 7'h3F on digits 3 and 2.
REQ-031 load 16'h00A5 -> after commit, digit 1 shows 7'h40, err=1, and digits 3 and 2 blank under blank_en=1.
REQ-032 load 16'h1111 then load 16'h2222 in the same frame, with a third load coinciding with the boundary cycle -> the 16'h2222 value is committed; the third value commits at the following boundary.
REQ-033 Assert rst during idx=2 with pending=1 -> all outputs take reset values; the pending value is lost; display restarts at digit 0 showing 7'h3F.
